// File: rtl/afg_pkg.sv
//============================================================================
// Module   : afg_pkg
// Brief    : Shared constants and types for the AFG PWM carrier/level path.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

package afg_pkg;

  localparam int DATA_W         = 20;
  localparam int UNDERRUN_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } afg_state_e;

  function automatic logic [UNDERRUN_CNT_W-1:0] sat_inc(
    input logic [UNDERRUN_CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pwm_ramp_gen_if.sv
//============================================================================
// Module   : pwm_ramp_gen_if
// Brief    : Valid/ready sample channel feeding the PWM level shadow buffer.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

interface pwm_ramp_gen_if #(
  parameter int WIDTH = afg_pkg::DATA_W
);

  logic [WIDTH-1:0] sample;
  logic             sample_valid;
  logic             sample_ready;

  modport master (
    output sample,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample,
    input  sample_valid,
    output sample_ready
  );

endinterface

`default_nettype wire

// File: rtl/sample_shadow_buf.sv
//============================================================================
// Module   : sample_shadow_buf
// Brief    : One-entry holding register with load, transfer and full flag.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module sample_shadow_buf #(
  parameter int WIDTH = 20
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             load_i,
  input  wire logic             transfer_i,
  input  wire logic [WIDTH-1:0] data_i,
  output logic      [WIDTH-1:0] data_o,
  output logic                  full_o
);

  logic [WIDTH-1:0] data_q;
  logic             full_q;

  // Load only happens when empty and transfer only when full, so the two
  // never collide on one clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else if (load_i && !full_q) begin
      data_q <= data_i;
      full_q <= 1'b1;
    end else if (transfer_i && full_q) begin
      full_q <= 1'b0;
    end
  end

  assign data_o = data_q;
  assign full_o = full_q;

endmodule

`default_nettype wire

// File: rtl/pwm_ramp_gen.sv
//============================================================================
// Module   : pwm_ramp_gen
// Brief    : Prescaled sawtooth carrier plus wrap-synchronous level update
//            for the 20-bit PWM comparator. Optional saturating underrun
//            counter enabled by PWM_RAMP_UNDERRUN_CNT_EN.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module pwm_ramp_gen
  import afg_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int PRE_W = 8
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             enable_i,
  input  wire logic [WIDTH-1:0] period_i,
  input  wire logic [PRE_W-1:0] prescale_i,
  pwm_ramp_gen_if.slave         smp_if,
  output logic      [WIDTH-1:0] ramp_o,
  output logic      [WIDTH-1:0] level_o,
  output logic                  wrap_pulse_o,
  output logic                  running_o,
  output logic                  underrun_o
`ifdef PWM_RAMP_UNDERRUN_CNT_EN
  ,
  output logic [UNDERRUN_CNT_W-1:0] underrun_cnt_o
`endif
);

  afg_state_e       state_q;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [WIDTH-1:0] ramp_q, ramp_d;
  logic [WIDTH-1:0] period_q;
  logic [WIDTH-1:0] level_q;
  logic             wrap_q;
  logic             running_q;
  logic             underrun_q;

  logic             w_counting;
  logic             w_tick;
  logic             w_wrap;
  logic             w_accept;
  logic             w_transfer;
  logic             w_buf_full;
  logic [WIDTH-1:0] w_buf_data;

  assign w_counting = (state_q != IDLE);
  // >= keeps the tick alive if Prescale is lowered below the running count.
  assign w_tick     = w_counting && (pre_q >= prescale_i);
  assign w_wrap     = w_tick && (ramp_q == period_q);
  assign w_accept   = smp_if.sample_valid && !w_buf_full;
  assign w_transfer = w_wrap && w_buf_full;

  assign smp_if.sample_ready = ~w_buf_full;

  sample_shadow_buf #(
    .WIDTH (WIDTH)
  ) u_shadow (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (w_accept),
    .transfer_i (w_transfer),
    .data_i     (smp_if.sample),
    .data_o     (w_buf_data),
    .full_o     (w_buf_full)
  );

  always_comb begin
    pre_d  = pre_q;
    ramp_d = ramp_q;
    if (w_counting) begin
      pre_d = w_tick ? '0 : pre_q + 1'b1;
      if (w_tick) begin
        ramp_d = w_wrap ? '0 : ramp_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pre_q      <= '0;
      ramp_q     <= '0;
      period_q   <= '0;
      level_q    <= '0;
      wrap_q     <= 1'b0;
      running_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      ramp_q <= ramp_d;
      wrap_q <= w_wrap;
      if (w_wrap) begin
        period_q <= period_i;
      end
      if (w_transfer) begin
        level_q <= w_buf_data;
      end else if (w_wrap) begin
        underrun_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (enable_i) begin
            state_q   <= RUN;
            running_q <= 1'b1;
            period_q  <= period_i;
            pre_q     <= '0;
          end
        end
        RUN: begin
          if (!enable_i) begin
            state_q <= STOP;
          end
        end
        STOP: begin
          if (enable_i) begin
            state_q <= RUN;
          end else if (w_wrap) begin
            state_q   <= IDLE;
            running_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  assign ramp_o       = ramp_q;
  assign level_o      = level_q;
  assign wrap_pulse_o = wrap_q;
  assign running_o    = running_q;
  assign underrun_o   = underrun_q;

`ifdef PWM_RAMP_UNDERRUN_CNT_EN
  logic [UNDERRUN_CNT_W-1:0] ucnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ucnt_q <= '0;
    end else if (w_wrap && !w_buf_full) begin
      ucnt_q <= sat_inc(ucnt_q);
    end
  end

  assign underrun_cnt_o = ucnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pwm_ramp_gen.sv
//============================================================================
// Module   : tb_pwm_ramp_gen
// Brief    : Self-checking bench for pwm_ramp_gen against a behavioural model.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_pwm_ramp_gen;
  import afg_pkg::*;

  localparam int W  = DATA_W;
  localparam int PW = 8;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          enable   = 1'b0;
  logic [W-1:0]  period   = '0;
  logic [PW-1:0] prescale = '0;
  logic [W-1:0]  ramp, level;
  logic          wrap, running, underrun;
`ifdef PWM_RAMP_UNDERRUN_CNT_EN
  logic [UNDERRUN_CNT_W-1:0] ucnt;
`endif

  int  checks = 0;
  int  errors = 0;
  bit  chk_en = 1'b0;

  pwm_ramp_gen_if #(.WIDTH(W)) smp_if ();

  pwm_ramp_gen #(.WIDTH(W), .PRE_W(PW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable_i       (enable),
    .period_i       (period),
    .prescale_i     (prescale),
    .smp_if         (smp_if.slave),
    .ramp_o         (ramp),
    .level_o        (level),
    .wrap_pulse_o   (wrap),
    .running_o      (running),
    .underrun_o     (underrun)
`ifdef PWM_RAMP_UNDERRUN_CNT_EN
    ,
    .underrun_cnt_o (ucnt)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural model: a counting flag, a "stop requested" flag, and a queue
  // standing in for the one-entry shadow buffer.
  int m_ramp, m_level, m_per, m_pre, m_ucnt;
  bit m_active, m_drain, m_wrap, m_under;
  int shadow[$];

  task automatic model_reset();
    m_ramp = 0; m_level = 0; m_per = 0; m_pre = 0; m_ucnt = 0;
    m_active = 0; m_drain = 0; m_wrap = 0; m_under = 0;
    shadow.delete();
  endtask

  task automatic model_step();
    bit acc, tick, wr;
    acc = smp_if.sample_valid && (shadow.size() == 0);
    wr  = 0;
    if (!m_active) begin
      if (enable) begin
        m_active = 1; m_drain = 0; m_per = int'(period); m_pre = 0;
      end
    end else begin
      tick  = (m_pre == int'(prescale));
      m_pre = tick ? 0 : m_pre + 1;
      if (tick) begin
        if (m_ramp == m_per) begin
          wr = 1; m_ramp = 0; m_per = int'(period);
          if (shadow.size() != 0) m_level = shadow.pop_front();
          else begin
            m_under = 1;
            if (m_ucnt < 65535) m_ucnt++;
          end
        end else begin
          m_ramp++;
        end
      end
      if (m_drain) begin
        if (enable) m_drain = 0;
        else if (wr) m_active = 0;
      end else if (!enable) begin
        m_drain = 1;
      end
    end
    if (acc) shadow.push_back(int'(smp_if.sample));
    m_wrap = wr;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("ramp",     ramp,                int'(m_ramp));
      chk("level",    level,               int'(m_level));
      chk("wrap",     wrap,                m_wrap);
      chk("running",  running,             m_active);
      chk("underrun", underrun,            m_under);
      chk("ready",    smp_if.sample_ready, shadow.size() == 0);
`ifdef PWM_RAMP_UNDERRUN_CNT_EN
      chk("ucnt",     ucnt,                m_ucnt);
`endif
    end
  end

  task automatic wait_wrap(input string tag);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!wrap && n < 200);
    if (!wrap) begin
      checks++; errors++;
      $display("FAIL %s: no wrap after %0d cycles, required a wrap", tag, n);
    end
  endtask

  task automatic wrap_interval(input string tag, input int exp);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!wrap && n < 200);
    chk(tag, n, exp);
  endtask

  task automatic wait_ramp(input string tag, input int v);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (int'(ramp) != v && n < 200);
    if (int'(ramp) != v) begin
      checks++; errors++;
      $display("FAIL %s: ramp %0d after %0d cycles, required %0d", tag, ramp, n, v);
    end
  endtask

  initial begin
    int seq_r[5];
    bit seq_run[5];
    smp_if.sample       = '0;
    smp_if.sample_valid = 1'b0;

    // Reset and initial state
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ramp", ramp, 0);
    chk("rst_level", level, 0);
    chk("rst_running", running, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_ready", smp_if.sample_ready, 1);
    chk_en = 1'b1;

    // Preload in IDLE, then Period=3 Prescale=0
    smp_if.sample       = 20'h12345;
    smp_if.sample_valid = 1'b1;
    period              = 20'd3;
    prescale            = '0;
    @(negedge clk);
    smp_if.sample_valid = 1'b0;
    chk("preload_ready_low", smp_if.sample_ready, 0);
    enable = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("p3_ramp",  ramp, i % 4);
      chk("p3_wrap",  wrap, (i == 4 || i == 8));
      chk("p3_level", level, (i >= 4) ? 32'h12345 : 32'h0);
      chk("p3_ready", smp_if.sample_ready, (i >= 4));
      chk("p3_under", underrun, (i >= 8));
    end
`ifdef PWM_RAMP_UNDERRUN_CNT_EN
    chk("p3_ucnt", ucnt, 1);
`endif

    // Period=2 Prescale=2: period change lands at next wrap
    period   = 20'd2;
    prescale = 8'd2;
    wait_wrap("p2_first_wrap");
    wrap_interval("p2_interval", 9);

    // Period=5, drop enable at ramp=1, change period to 9 mid-period
    period   = 20'd5;
    prescale = '0;
    wait_wrap("p5_first_wrap");
    wait_ramp("p5_ramp1", 1);
    enable = 1'b0;
    period = 20'd9;
    seq_r   = '{2, 3, 4, 5, 0};
    seq_run = '{1, 1, 1, 1, 0};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stop_ramp",    ramp,    seq_r[i]);
      chk("stop_running", running, seq_run[i]);
      chk("stop_wrap",    wrap,    (i == 4));
    end
    @(negedge clk);
    chk("idle_ramp",    ramp,    0);
    chk("idle_running", running, 0);
    enable = 1'b1;
    wait_wrap("p9_first_wrap");
    wrap_interval("p9_interval", 10);

    // Asynchronous reset mid-run at ramp=7
    wait_ramp("rst_at7", 7);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ramp",     ramp,     0);
    chk("arst_level",    level,    0);
    chk("arst_wrap",     wrap,     0);
    chk("arst_running",  running,  0);
    chk("arst_underrun", underrun, 0);
    chk("arst_ready",    smp_if.sample_ready, 1);
    @(posedge clk); #1 rst_n = 1'b1;

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      int np;
      @(negedge clk);
      if ($urandom_range(0, 99) < 3) enable = ~enable;
      if ($urandom_range(0, 99) < 5) period = W'($urandom_range(0, 6));
      if ($urandom_range(0, 99) < 5) begin
        np = int'($urandom_range(0, 3));
        if (np >= m_pre) prescale = PW'(np);
      end
      smp_if.sample_valid = ($urandom_range(0, 99) < 30);
      smp_if.sample       = W'($urandom);
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
